// File: rtl/bsg_bp_mem_channel_splitter.sv
// N-way BedRock memory command splitter: steers commands to interleaved channels and
// returns responses in command order through an order FIFO of channel ids.
module bsg_bp_mem_channel_splitter #(
    parameter int unsigned num_channels_p    = 2,
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned paddr_width_p     = 40,
    parameter int unsigned block_offset_p    = 6,
    parameter int unsigned hash_mode_p       = 0,
    parameter int unsigned max_outstanding_p = 8,
    localparam int unsigned lg_lp    = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
    localparam int unsigned cnt_w_lp = $clog2(max_outstanding_p + 1),
    localparam int unsigned ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [msg_width_p-1:0]                cmd_i,
    input  logic [paddr_width_p-1:0]              cmd_addr_i,
    input  logic                                  cmd_v_i,
    output logic                                  cmd_ready_o,
    output logic [msg_width_p-1:0]                resp_o,
    output logic                                  resp_v_o,
    input  logic                                  resp_yumi_i,
    output logic [num_channels_p*msg_width_p-1:0] chan_cmd_o,
    output logic [num_channels_p-1:0]             chan_cmd_v_o,
    input  logic [num_channels_p-1:0]             chan_cmd_ready_i,
    input  logic [num_channels_p*msg_width_p-1:0] chan_resp_i,
    input  logic [num_channels_p-1:0]             chan_resp_v_i,
    output logic [num_channels_p-1:0]             chan_resp_yumi_o,
    output logic [cnt_w_lp-1:0]                   outstanding_o,
    output logic                                  err_o
);

    localparam int unsigned span_lp   = paddr_width_p - block_offset_p;
    localparam int unsigned chunks_lp = (span_lp + lg_lp - 1) / lg_lp;
    localparam logic [cnt_w_lp-1:0] max_cnt_lp  = cnt_w_lp'(max_outstanding_p);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(max_outstanding_p - 1);

    logic [lg_lp-1:0]    fifo_q [max_outstanding_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] outstanding_q, outstanding_d;
    logic [cnt_w_lp-1:0] cnt_q [num_channels_p];
    logic [cnt_w_lp-1:0] cnt_d [num_channels_p];
    logic                err_q, err_d;

    logic [span_lp-1:0]        span;
    logic [lg_lp-1:0]          sel;
    logic [lg_lp-1:0]          head;
    logic                      full, empty;
    logic                      ready_sel;
    logic                      fire, pop;
    logic [num_channels_p-1:0] inc_vec, dec_vec;
    logic                      sat_err, unsolicited, bad_yumi;

    assign span = cmd_addr_i[paddr_width_p-1:block_offset_p];

    if (block_offset_p > 0) begin : g_unused_offset
        logic unused_offset_bits;
        assign unused_offset_bits = ^cmd_addr_i[block_offset_p-1:0];
    end

    // Hash mode folds every lg-bit chunk above the granule; the shift zero-pads the top one.
    always_comb begin
        sel = '0;
        if (num_channels_p > 1) begin
            if (hash_mode_p == 0) begin
                sel = cmd_addr_i[block_offset_p +: lg_lp];
            end else begin
                for (int k = 0; k < chunks_lp; k++) begin
                    sel = sel ^ lg_lp'(span >> (k * lg_lp));
                end
            end
        end
    end

    assign full  = (outstanding_q == max_cnt_lp);
    assign empty = (outstanding_q == '0);
    assign head  = fifo_q[rptr_q];

    always_comb begin
        ready_sel = 1'b0;
        for (int c = 0; c < num_channels_p; c++) begin
            if (lg_lp'(c) == sel) begin
                ready_sel = chan_cmd_ready_i[c];
            end
        end
    end

    assign chan_cmd_o  = {num_channels_p{cmd_i}};
    assign cmd_ready_o = reset_n_i & ~full & ready_sel;
    assign fire        = cmd_v_i & cmd_ready_o;
    assign pop         = resp_yumi_i & ~empty;

    always_comb begin
        chan_cmd_v_o     = '0;
        chan_resp_yumi_o = '0;
        inc_vec          = '0;
        dec_vec          = '0;
        resp_o           = '0;
        resp_v_o         = 1'b0;
        for (int c = 0; c < num_channels_p; c++) begin
            chan_cmd_v_o[c]     = reset_n_i & cmd_v_i & ~full & (lg_lp'(c) == sel);
            chan_resp_yumi_o[c] = resp_yumi_i & ~empty & (lg_lp'(c) == head);
            inc_vec[c]          = fire & (lg_lp'(c) == sel);
            dec_vec[c]          = pop & (lg_lp'(c) == head);
            if (lg_lp'(c) == head) begin
                resp_o   = chan_resp_i[c*msg_width_p +: msg_width_p];
                resp_v_o = ~empty & chan_resp_v_i[c];
            end
        end
    end

    // Counters hold their value on saturation; hitting a rail flags a protocol error.
    always_comb begin
        cnt_d       = cnt_q;
        sat_err     = 1'b0;
        unsolicited = 1'b0;
        for (int c = 0; c < num_channels_p; c++) begin
            if (chan_resp_v_i[c] && (cnt_q[c] == '0)) begin
                unsolicited = 1'b1;
            end
            if (inc_vec[c] && !dec_vec[c]) begin
                if (cnt_q[c] == max_cnt_lp) begin
                    sat_err = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end else if (dec_vec[c] && !inc_vec[c]) begin
                if (cnt_q[c] == '0) begin
                    sat_err = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] - 1'b1;
                end
            end
        end
    end

    assign bad_yumi = resp_yumi_i & ~resp_v_o;
    assign err_d    = err_q | bad_yumi | unsolicited | sat_err;

    always_comb begin
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        outstanding_d = outstanding_q;
        if (fire) begin
            wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
        end
        if (fire && !pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (pop && !fire) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            fifo_q[wptr_q] <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q        <= '0;
            wptr_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            for (int c = 0; c < num_channels_p; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

endmodule
